// File: rtl/wb_macro_pkg.sv
// Shared constants for the macro-side Wishbone register block.
// Covers the register map offsets, the user register stride and the FSM encoding.
package wb_macro_pkg;
  localparam int ADR_W = 12;
  localparam int DAT_W = 32;

  localparam logic [ADR_W-1:0] OFS_ID        = 12'h000;
  localparam logic [ADR_W-1:0] OFS_CTRL      = 12'h004;
  localparam logic [ADR_W-1:0] OFS_STATUS    = 12'h008;
  localparam logic [ADR_W-1:0] OFS_IRQ_EN    = 12'h00C;
  localparam logic [ADR_W-1:0] OFS_IRQ_PEND  = 12'h010;
  localparam logic [ADR_W-1:0] OFS_IRQ_SET   = 12'h014;
  localparam logic [ADR_W-1:0] OFS_USER_BASE = 12'h020;
  localparam int               USER_STRIDE   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // The bus has no byte selects, so decode works on the word index.
  function automatic logic [ADR_W-3:0] word_idx(input logic [ADR_W-1:0] a);
    return a[ADR_W-1:2];
  endfunction
endpackage

// File: rtl/wb_macro_regs_if.sv
// Divided-clock Wishbone link between the local bridge (master) and one user macro (slave).
interface wb_macro_regs_if;
  import wb_macro_pkg::*;

  logic             wbs_cs_i;
  logic             wbs_we_i;
  logic [ADR_W-1:0] wbs_adr_i;
  logic [DAT_W-1:0] wbs_dat_i;
  logic             wbs_ack_o;
  logic [DAT_W-1:0] wbs_dat_o;

  modport master (
    output wbs_cs_i, wbs_we_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cs_i, wbs_we_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_macro_irq.sv
// Interrupt enable/pending state with W1C, software set, event set and a registered irq.
module wb_macro_irq
  import wb_macro_pkg::*;
#(
  parameter int IRQ_W = 4
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n_i,
  input  logic             en_we,
  input  logic [IRQ_W-1:0] en_wdata,
  input  logic [IRQ_W-1:0] clr_mask,
  input  logic [IRQ_W-1:0] set_mask,
  input  logic [IRQ_W-1:0] evt_i,
  output logic [IRQ_W-1:0] en_o,
  output logic [IRQ_W-1:0] pend_o,
  output logic             irq_o
);

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      en_o   <= '0;
      pend_o <= '0;
      irq_o  <= 1'b0;
    end else begin
      if (en_we) en_o <= en_wdata;
      // Clear is applied first so a same-cycle event or software set wins.
      pend_o <= (pend_o & ~clr_mask) | set_mask | evt_i;
      irq_o  <= |(pend_o & en_o);
    end
  end

endmodule

// File: rtl/wb_macro_regs.sv
// Macro-side Wishbone responder: chip-select decode, fixed register map, one-cycle ack
// and masked interrupt, all on the divided macro clock.
module wb_macro_regs
  import wb_macro_pkg::*;
#(
  parameter logic [31:0] MACRO_ID = 32'h0000_0000,
  parameter int          N_USER   = 4,
  parameter int          IRQ_W    = 4
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_n_i,
  wb_macro_regs_if.slave      wb,
  output logic [31:0]         ctrl_o,
  output logic                ctrl_wr_o,
  output logic [32*N_USER-1:0] user_o,
  output logic [N_USER-1:0]   user_wr_o,
  input  logic [31:0]         status_i,
  input  logic [IRQ_W-1:0]    evt_i,
  output logic                irq_o
);

  state_e                   state;
  logic [ADR_W-3:0]         wadr;
  logic                     access, wr;
  logic                     hit_ctrl, hit_en, hit_pend, hit_set;
  logic [N_USER-1:0]        hit_user;
  logic [N_USER-1:0][31:0]  user_q;
  logic [DAT_W-1:0]         rd_data;
  logic [IRQ_W-1:0]         irq_en, irq_pend, clr_mask, set_mask;

  assign wadr   = word_idx(wb.wbs_adr_i);
  assign access = (state == ST_IDLE) && wb.wbs_cs_i;
  assign wr     = access && wb.wbs_we_i;

  assign hit_ctrl = (wadr == word_idx(OFS_CTRL));
  assign hit_en   = (wadr == word_idx(OFS_IRQ_EN));
  assign hit_pend = (wadr == word_idx(OFS_IRQ_PEND));
  assign hit_set  = (wadr == word_idx(OFS_IRQ_SET));

  genvar k;
  generate
    for (k = 0; k < N_USER; k++) begin : g_user_dec
      localparam logic [ADR_W-1:0] UOFS = OFS_USER_BASE + ADR_W'(k * USER_STRIDE);
      assign hit_user[k] = (wadr == word_idx(UOFS));
    end
  endgenerate

  assign clr_mask = (wr && hit_pend) ? wb.wbs_dat_i[IRQ_W-1:0] : '0;
  assign set_mask = (wr && hit_set)  ? wb.wbs_dat_i[IRQ_W-1:0] : '0;

  wb_macro_irq #(.IRQ_W(IRQ_W)) u_irq (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_n_i (wb_rst_n_i),
    .en_we      (wr && hit_en),
    .en_wdata   (wb.wbs_dat_i[IRQ_W-1:0]),
    .clr_mask   (clr_mask),
    .set_mask   (set_mask),
    .evt_i      (evt_i),
    .en_o       (irq_en),
    .pend_o     (irq_pend),
    .irq_o      (irq_o)
  );

  // Read mux; IRQ_SET and unmapped words fall through to zero.
  always_comb begin
    rd_data = '0;
    if (wadr == word_idx(OFS_ID))          rd_data = MACRO_ID;
    else if (hit_ctrl)                     rd_data = ctrl_o;
    else if (wadr == word_idx(OFS_STATUS)) rd_data = status_i;
    else if (hit_en)                       rd_data[IRQ_W-1:0] = irq_en;
    else if (hit_pend)                     rd_data[IRQ_W-1:0] = irq_pend;
    else begin
      for (int i = 0; i < N_USER; i++)
        if (hit_user[i]) rd_data = user_q[i];
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      user_q    <= '0;
      user_wr_o <= '0;
    end else begin
      for (int i = 0; i < N_USER; i++) begin
        user_wr_o[i] <= wr && hit_user[i];
        if (wr && hit_user[i]) user_q[i] <= wb.wbs_dat_i;
      end
    end
  end

  assign user_o = user_q;

  // Bus FSM: side effects land on the IDLE->ACK edge so they coincide with ack.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state        <= ST_IDLE;
      wb.wbs_ack_o <= 1'b0;
      wb.wbs_dat_o <= '0;
      ctrl_o       <= '0;
      ctrl_wr_o    <= 1'b0;
    end else begin
      wb.wbs_ack_o <= 1'b0;
      wb.wbs_dat_o <= '0;
      ctrl_wr_o    <= 1'b0;
      case (state)
        ST_IDLE: if (wb.wbs_cs_i) begin
          state        <= ST_ACK;
          wb.wbs_ack_o <= 1'b1;
          wb.wbs_dat_o <= wb.wbs_we_i ? '0 : rd_data;
          if (wb.wbs_we_i && hit_ctrl) begin
            ctrl_o    <= wb.wbs_dat_i;
            ctrl_wr_o <= 1'b1;
          end
        end
        ST_ACK:  state <= ST_HOLD;
        ST_HOLD: if (!wb.wbs_cs_i) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
